alu_mul_sequencer: RTL and testbench

//  Multi-cycle unsigned multiply (MULTU) controller that borrows the shared 32-bit ALU.

---
 rtl/alu_mul_sequencer.sv | 119 +++++++++++
 tb/tb_alu_mul_sequencer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/alu_mul_sequencer.sv
// Purpose: multi-cycle unsigned multiply (MULTU) that borrows the shared ALU for one ADD per
//          iteration of a shift-add loop, producing a 2*WIDTH-bit product.
// Ports:   clk_i/rst_ni (async active-low); start_i/op_a_i/op_b_i request a multiply;
//          ready_o/busy_o/done_o report state; prod_hi_o/prod_lo_o hold the last product;
//          alu_req_o/alu_a_o/alu_b_o/alu_signal_o drive the borrowed ALU, alu_result_i returns its sum.
module alu_mul_sequencer #(
  parameter int          WIDTH    = 32,
  parameter int          CNT_W    = 6,
  parameter logic [5:0]  ADD_CODE = 6'b100000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] prod_hi_o,
  output logic [WIDTH-1:0] prod_lo_o,
  output logic             alu_req_o,
  output logic [WIDTH-1:0] alu_a_o,
  output logic [WIDTH-1:0] alu_b_o,
  output logic [5:0]       alu_signal_o,
  input  logic [WIDTH-1:0] alu_result_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] prod_hi_q, prod_hi_d;
  logic [WIDTH-1:0] prod_lo_q, prod_lo_d;
  logic             carry;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      mcand_q   <= '0;
      cnt_q     <= '0;
      prod_hi_q <= '0;
      prod_lo_q <= '0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      mcand_q   <= mcand_d;
      cnt_q     <= cnt_d;
      prod_hi_q <= prod_hi_d;
      prod_lo_q <= prod_lo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    mcand_d   = mcand_q;
    cnt_d     = cnt_q;
    prod_hi_d = prod_hi_q;
    prod_lo_d = prod_lo_q;
    carry     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
          hi_d    = '0;
          lo_d    = op_b_i;
          mcand_d = op_a_i;
          cnt_d   = '0;
        end
      end
      RUN: begin
        // The ALU only returns WIDTH bits; a wrapped sum is smaller than the addend hi,
        // which recovers the carry-out without a wider adder.
        carry = (alu_result_i < hi_q);
        // {hi, lo} <= {carry, sum, lo} >> 1: the sum's LSB falls into the top of lo.
        hi_d  = {carry, alu_result_i[WIDTH-1:1]};
        lo_d  = {alu_result_i[0], lo_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) begin
          state_d   = DONE;
          prod_hi_d = hi_d;
          prod_lo_d = lo_d;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ready_o      = (state_q == IDLE);
  assign busy_o       = (state_q == RUN);
  assign done_o       = (state_q == DONE);
  assign alu_req_o    = (state_q == RUN);
  assign alu_signal_o = (state_q == RUN) ? ADD_CODE : 6'b000000;
  assign alu_a_o      = hi_q;
  // The multiplier bit under test is always lo[0]; lo shifts right every iteration.
  assign alu_b_o      = lo_q[0] ? mcand_q : '0;
  assign prod_hi_o    = prod_hi_q;
  assign prod_lo_o    = prod_lo_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
module tb_alu_mul_sequencer;
  localparam int         WIDTH = 32;
  localparam logic [5:0] ADD   = 6'b100000;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] op_a, op_b;
  logic             ready, busy, done, alu_req;
  logic [WIDTH-1:0] prod_hi, prod_lo, alu_a, alu_b, alu_result;
  logic [5:0]       alu_signal;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  // Shared ALU stand-in: adds only when asked to ADD, otherwise returns junk that must be ignored.
  assign alu_result = (alu_signal == ADD) ? (alu_a + alu_b) : 32'hDEAD_BEEF;

  alu_mul_sequencer dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .op_a_i       (op_a),
    .op_b_i       (op_b),
    .ready_o      (ready),
    .busy_o       (busy),
    .done_o       (done),
    .prod_hi_o    (prod_hi),
    .prod_lo_o    (prod_lo),
    .alu_req_o    (alu_req),
    .alu_a_o      (alu_a),
    .alu_b_o      (alu_b),
    .alu_signal_o (alu_signal),
    .alu_result_i (alu_result)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on zero-extended operands.
  function automatic logic [63:0] ref_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [63:0] wa, wb;
    wa = {32'b0, a};
    wb = {32'b0, b};
    return wa * wb;
  endfunction

  // One complete multiply. inj_at > 0 pulses start with fresh operands that many cycles
  // after acceptance; it must be ignored.
  task automatic do_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int inj_at);
    logic [63:0] exp;
    int edges;
    exp = ref_mul(a, b);
    @(negedge clk);
    chk("ready_idle", {63'b0, ready}, 64'd1);
    start = 1'b1; op_a = a; op_b = b;
    @(negedge clk);
    start = 1'b0; op_a = $urandom; op_b = $urandom;
    chk("run_flags", {60'b0, busy, ready, alu_req, done}, {60'b0, 4'b1010});
    chk("run_alu_sig", {58'b0, alu_signal}, {58'b0, ADD});
    edges = 0;
    while (!done && edges < WIDTH + 8) begin
      @(negedge clk);
      edges++;
      if (edges == inj_at) begin
        chk("ready_low_busy", {63'b0, ready}, 64'd0);
        start = 1'b1; op_a = $urandom; op_b = $urandom;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk("latency", 64'(edges), 64'(WIDTH));
    chk("done_pulse", {63'b0, done}, 64'd1);
    chk("product", {prod_hi, prod_lo}, exp);
    @(negedge clk);
    chk("after_done_flags", {61'b0, done, busy, ready}, {61'b0, 3'b001});
    chk("product_hold", {prod_hi, prod_lo}, exp);
  endtask

  initial begin
    int edges;
    int inj;
    logic [WIDTH-1:0] ra, rb;

    rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_flags", {60'b0, ready, busy, done, alu_req}, {60'b0, 4'b1000});
    chk("rst_prod", {prod_hi, prod_lo}, 64'd0);
    chk("rst_alu_sig", {58'b0, alu_signal}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_stays", {62'b0, ready, busy}, {62'b0, 2'b10});

    // Directed cases: small product, carry path, zero operands, ignored start mid-run.
    do_mul(32'd3, 32'd5, -1);
    do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    do_mul(32'h1234_5678, 32'd0, -1);
    do_mul(32'd0, 32'hFFFF_FFFF, -1);
    do_mul(32'hCAFE_F00D, 32'h0BAD_BEEF, 10);
    do_mul(32'h8000_0001, 32'hFFFF_FFFF, WIDTH);

    // Reset in the middle of a run discards it.
    @(negedge clk);
    start = 1'b1; op_a = 32'hABCD; op_b = 32'h1234;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_flags", {60'b0, ready, busy, done, alu_req}, {60'b0, 4'b1000});
    chk("midrst_prod", {prod_hi, prod_lo}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    edges = 0;
    for (int i = 0; i < WIDTH + 6; i++) begin
      @(negedge clk);
      if (done) edges++;
    end
    chk("midrst_no_done", 64'(edges), 64'd0);
    do_mul(32'd7, 32'd9, -1);

    // Start held high: back-to-back acceptance every WIDTH+2 cycles.
    @(negedge clk);
    start = 1'b1; op_a = 32'd6; op_b = 32'd7;
    edges = 0;
    while (!done && edges < WIDTH + 8) begin
      @(negedge clk);
      edges++;
    end
    chk("held_first", {prod_hi, prod_lo}, 64'd42);
    op_a = 32'd8; op_b = 32'd8;
    edges = 0;
    @(negedge clk);
    edges++;
    while (!done && edges < 2 * WIDTH) begin
      @(negedge clk);
      edges++;
    end
    start = 1'b0;
    chk("held_spacing", 64'(edges), 64'(WIDTH + 2));
    chk("held_second", {prod_hi, prod_lo}, 64'd64);
    @(negedge clk);
    @(negedge clk);
    chk("held_release_idle", {62'b0, ready, busy}, {62'b0, 2'b10});

    // Random operands, some with ignored start pulses.
    for (int n = 0; n < 12; n++) begin
      ra = $urandom;
      rb = $urandom;
      if (n == 3) ra = 32'hFFFF_FFFF;
      if (n == 7) rb = 32'h0000_0001;
      inj = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, WIDTH)) : -1;
      do_mul(ra, rb, inj);
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
